// File: rtl/y86_alu_exec.sv
// Registered Y86 execute ALU (add/sub/and/xor) with ZF/SF/OF CC register and cmov/jXX condition evaluator.
// Latency 1 cycle, full throughput; in_ready drops during flush or while a result is held under out_ready=0.
module y86_alu_exec #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic [TAG_W-1:0] out_tag,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  input  logic [3:0]       cond_fn,
  output logic             cond_true
);

  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             sf;
    logic             of;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t res_d;
  res_t res_q;
  logic out_valid_q;
  logic cc_zf_q;
  logic cc_sf_q;
  logic cc_of_q;
  logic accept;
  logic sxor;

  always_comb begin
    res_d     = '0;
    res_d.tag = in_tag;
    case (in_fn)
      2'd0: begin
        res_d.result = in_a + in_b;
        res_d.of     = (in_a[MSB] == in_b[MSB]) && (res_d.result[MSB] != in_a[MSB]);
      end
      2'd1: begin
        res_d.result = in_a - in_b;
        res_d.of     = (in_a[MSB] != in_b[MSB]) && (res_d.result[MSB] != in_a[MSB]);
      end
      2'd2:    res_d.result = in_a & in_b;
      default: res_d.result = in_a ^ in_b;
    endcase
    res_d.zf = (res_d.result == '0);
    res_d.sf = res_d.result[MSB];
  end

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Data fields are left untouched when out_valid drops; only the valid bit is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // CC commits at accept; a later flush of the held result does not roll it back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf_q <= 1'b1;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else if (accept && in_set_cc) begin
      cc_zf_q <= res_d.zf;
      cc_sf_q <= res_d.sf;
      cc_of_q <= res_d.of;
    end
  end

  assign sxor = cc_sf_q ^ cc_of_q;

  always_comb begin
    cond_true = 1'b0;
    case (cond_fn)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = sxor | cc_zf_q;
      4'd2:    cond_true = sxor;
      4'd3:    cond_true = cc_zf_q;
      4'd4:    cond_true = !cc_zf_q;
      4'd5:    cond_true = !sxor;
      4'd6:    cond_true = !sxor && !cc_zf_q;
      default: cond_true = 1'b0;
    endcase
  end

  assign out_valid  = out_valid_q;
  assign out_result = res_q.result;
  assign out_zf     = res_q.zf;
  assign out_sf     = res_q.sf;
  assign out_of     = res_q.of;
  assign out_tag    = res_q.tag;
  assign cc_zf      = cc_zf_q;
  assign cc_sf      = cc_sf_q;
  assign cc_of      = cc_of_q;

endmodule
